// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle between the pipeline and the register file.
//   Parameters XLEN / NREGS / NRD must match the attached regfile_mp.
//   master (pipeline side): drives read addresses, writeback, issue,
//                           flush and clr_start; observes rd_data, rd_busy,
//                           clr_busy.
//   slave  (register file): the mirror image.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic                clr_start;
  logic                clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush, clr_start,
    input  rd_data, rd_busy, clr_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush, clr_start,
    output rd_data, rd_busy, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with same-cycle write bypass,
// per-register busy scoreboard and a sequential bulk-clear engine.
//   clk_i    : clock, all state changes on the rising edge
//   reset_ni : asynchronous active-low reset
//   bus      : regfile_mp_if.slave
//              rd_addr/rd_data/rd_busy  combinational read ports (NRD)
//              wr_en/wr_addr/wr_data    writeback (also clears busy)
//              iss_en/iss_addr          issue (sets busy)
//              flush                    clears every busy bit
//              clr_start/clr_busy       bulk clear, one register per cycle
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  regfile_mp_if.slave  bus
);
  localparam int            AW   = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [AW-1:0]     cnt_q;
  logic              clr_busy_q;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic idle;
  logic wr_ok;
  logic bypass_en;

  assign idle  = (state_q == IDLE);
  // Register 0 is never written when it is hardwired to zero.
  assign wr_ok = idle && bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
  // Bypass is gated by reset so that reads see the cleared array while
  // reset is held, whatever the writeback inputs are doing.
  assign bypass_en = reset_ni && idle && bus.wr_en;

  // Clear engine: counter walks 0..NREGS-1, one zeroing write per cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_start) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;  // wraps back to 0 after LAST
          if (cnt_q == LAST) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clr_busy = clr_busy_q;

  // Storage array: clear engine has priority; external writes only in IDLE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (!idle) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard next state. Issue after writeback so a same-address pair
  // leaves the register pending for the newly issued producer.
  always_comb begin
    busy_d = busy_q;
    if (idle) begin
      if (bus.clr_start) begin
        busy_d = '0;
      end else begin
        if (bus.wr_en)  busy_d[bus.wr_addr]  = 1'b0;
        if (bus.iss_en) busy_d[bus.iss_addr] = 1'b1;
      end
    end
    if (bus.flush) busy_d = '0;
    if (ZERO_REG)  busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) busy_q <= '0;
    else           busy_q <= busy_d;
  end

  // Independent combinational read ports.
  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            busy;

      assign addr = bus.rd_addr[gi*AW +: AW];

      always_comb begin
        data = regs_q[addr];
        busy = busy_q[addr];
        if (ZERO_REG && (addr == '0)) begin
          data = '0;
          busy = 1'b0;
        end else if (bypass_en && (bus.wr_addr == addr)) begin
          data = bus.wr_data;
          busy = 1'b0;
        end
      end

      assign bus.rd_data[gi*XLEN +: XLEN] = data;
      assign bus.rd_busy[gi]              = busy;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives two register files (default 32x32/2-port with zero
// register, and 64-bit/16-entry/3-port without) from one stimulus stream and
// compares each, phase by phase, against a behavioural model.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus (sized for the larger configuration)
  logic [4:0]  d_ra [3];
  logic        d_wr_en = 1'b0;
  logic [4:0]  d_wr_addr = '0;
  logic [63:0] d_wr_data = '0;
  logic        d_iss_en = 1'b0;
  logic [4:0]  d_iss_addr = '0;
  logic        d_flush = 1'b0;
  logic        d_clr_start = 1'b0;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) bus_b ();

  assign bus_a.rd_addr   = {d_ra[1], d_ra[0]};
  assign bus_a.wr_en     = d_wr_en;
  assign bus_a.wr_addr   = d_wr_addr;
  assign bus_a.wr_data   = d_wr_data[31:0];
  assign bus_a.iss_en    = d_iss_en;
  assign bus_a.iss_addr  = d_iss_addr;
  assign bus_a.flush     = d_flush;
  assign bus_a.clr_start = d_clr_start;

  assign bus_b.rd_addr   = {d_ra[2][3:0], d_ra[1][3:0], d_ra[0][3:0]};
  assign bus_b.wr_en     = d_wr_en;
  assign bus_b.wr_addr   = d_wr_addr[3:0];
  assign bus_b.wr_data   = d_wr_data;
  assign bus_b.iss_en    = d_iss_en;
  assign bus_b.iss_addr  = d_iss_addr[3:0];
  assign bus_b.flush     = d_flush;
  assign bus_b.clr_start = d_clr_start;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1)) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus_a));
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(1'b0)) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus_b));

  // Active configuration
  int          sel;
  int          nregs;
  int          nrd;
  bit          zr;
  logic [63:0] mask;

  // Reference model
  logic [63:0] m_regs [32];
  bit          m_busy [32];
  int          m_clr_left;
  int          m_clr_idx;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_data(input int p);
    if (sel == 0) return {32'b0, bus_a.rd_data[p*32 +: 32]};
    return bus_b.rd_data[p*64 +: 64];
  endfunction

  function automatic logic obs_busy(input int p);
    if (sel == 0) return bus_a.rd_busy[p];
    return bus_b.rd_busy[p];
  endfunction

  function automatic logic obs_clr();
    if (sel == 0) return bus_a.clr_busy;
    return bus_b.clr_busy;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_clr_left = 0;
    m_clr_idx  = 0;
  endtask

  task automatic model_read(input int a, output logic [63:0] d, output logic b);
    if (zr && a == 0) begin
      d = '0; b = 1'b0;
    end else if (rst_n && m_clr_left == 0 && d_wr_en && int'(d_wr_addr) == a) begin
      d = d_wr_data & mask; b = 1'b0;
    end else begin
      d = m_regs[a]; b = m_busy[a];
    end
  endtask

  task automatic model_edge();
    int wa, ia;
    wa = int'(d_wr_addr);
    ia = int'(d_iss_addr);
    if (m_clr_left == 0) begin
      if (d_wr_en && !(zr && wa == 0)) m_regs[wa] = d_wr_data & mask;
      if (d_clr_start) begin
        m_clr_left = nregs;
        m_clr_idx  = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (d_wr_en)  m_busy[wa] = 1'b0;
        if (d_iss_en) m_busy[ia] = 1'b1;
      end
    end else begin
      m_regs[m_clr_idx] = '0;
      m_clr_idx  = m_clr_idx + 1;
      m_clr_left = m_clr_left - 1;
    end
    if (d_flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    if (zr) m_busy[0] = 1'b0;
  endtask

  task automatic idle_in();
    for (int p = 0; p < 3; p++) d_ra[p] = '0;
    d_wr_en = 1'b0; d_wr_addr = '0; d_wr_data = '0;
    d_iss_en = 1'b0; d_iss_addr = '0; d_flush = 1'b0; d_clr_start = 1'b0;
  endtask

  // Sample on the falling edge, compare every port with the model.
  task automatic at_neg(input string tag);
    logic [63:0] ed;
    logic        eb;
    @(negedge clk);
    for (int p = 0; p < nrd; p++) begin
      model_read(int'(d_ra[p]), ed, eb);
      check_eq($sformatf("%s_data%0d", tag, p), obs_data(p), ed);
      check_eq($sformatf("%s_busy%0d", tag, p), 64'(obs_busy(p)), 64'(eb));
    end
    check_eq($sformatf("%s_clr", tag), 64'(obs_clr()), 64'(m_clr_left > 0));
    $display("[TB] %s dut=%s ra0=%0d wr=%0b/%0d/%h iss=%0b/%0d fl=%0b cs=%0b clr_busy=%0b",
             tag, (sel == 0) ? "A" : "B", d_ra[0], d_wr_en, d_wr_addr, d_wr_data,
             d_iss_en, d_iss_addr, d_flush, d_clr_start, obs_clr());
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_reg(input int a, input logic [63:0] v);
    idle_in();
    d_wr_en = 1'b1; d_wr_addr = 5'(a); d_wr_data = v;
    at_neg("wr");
    edge_step();
  endtask

  task automatic run_phase();
    logic [63:0] pat;
    int          cnt;
    pat = 64'hA5A5A5A5_A5A5A5A5 & mask;

    // Reset with arbitrary inputs: everything reads zero.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 3; p++) d_ra[p] = 5'($urandom_range(0, nregs - 1));
      d_wr_en = 1'b1; d_wr_addr = d_ra[0]; d_wr_data = {$urandom, $urandom};
      d_iss_en = 1'($urandom); d_iss_addr = 5'($urandom_range(0, nregs - 1));
      #1;
      for (int p = 0; p < nrd; p++) begin
        check_eq("rst_data", obs_data(p), 64'h0);
        check_eq("rst_busy", 64'(obs_busy(p)), 64'h0);
      end
      check_eq("rst_clr", 64'(obs_clr()), 64'h0);
    end
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;

    // First write after reset
    write_reg(5, 64'hDEADBEEF);
    idle_in(); d_ra[0] = 5;
    at_neg("rd_r5");
    check_eq("r5_value", obs_data(0), 64'hDEADBEEF);
    check_eq("r5_busy", 64'(obs_busy(0)), 64'h0);
    edge_step();

    // Same-cycle bypass on every port
    idle_in();
    d_wr_en = 1'b1; d_wr_addr = 7; d_wr_data = 64'h12345678;
    for (int p = 0; p < 3; p++) d_ra[p] = 7;
    at_neg("bypass");
    for (int p = 0; p < nrd; p++) check_eq("bypass_data", obs_data(p), 64'h12345678);
    edge_step();

    // Register 0: hardwired zero (A) or ordinary (B)
    write_reg(0, (zr ? 64'hFFFFFFFF : 64'h5));
    idle_in(); d_ra[0] = 5; d_ra[1] = 7; d_ra[2] = 0;
    at_neg("ports");
    check_eq("port0_r5", obs_data(0), 64'hDEADBEEF);
    check_eq("port1_r7", obs_data(1), 64'h12345678);
    idle_in(); d_ra[0] = 0;
    edge_step();
    at_neg("r0");
    check_eq("r0_value", obs_data(0), (zr ? 64'h0 : 64'h5));
    edge_step();

    // Scoreboard
    idle_in(); d_iss_en = 1'b1; d_iss_addr = 9; d_ra[0] = 9;
    at_neg("iss9"); edge_step();
    idle_in(); d_ra[0] = 9; d_wr_en = 1'b1; d_wr_addr = 9; d_wr_data = 64'h99;
    d_iss_en = 1'b1; d_iss_addr = 9;
    at_neg("wr_iss9");
    check_eq("iss9_set", 64'(obs_busy(0)), 64'h0);  // bypass reports not busy
    edge_step();
    idle_in(); d_ra[0] = 9;
    at_neg("chk9");
    check_eq("wr_iss9_busy", 64'(obs_busy(0)), 64'h1);
    d_wr_en = 1'b1; d_wr_addr = 9; d_wr_data = 64'h77;
    at_neg("wr9");
    check_eq("wr9_bypass_busy", 64'(obs_busy(0)), 64'h0);
    edge_step();
    idle_in(); d_ra[0] = 9;
    at_neg("chk9b");
    check_eq("wr9_busy", 64'(obs_busy(0)), 64'h0);
    d_iss_en = 1'b1; d_iss_addr = 3; d_flush = 1'b1; d_ra[1] = 3;
    at_neg("iss3_flush"); edge_step();
    idle_in(); d_ra[0] = 3;
    at_neg("chk3");
    check_eq("flush_busy3", 64'(obs_busy(0)), 64'h0);
    edge_step();

    // Bulk clear
    for (int a = 0; a < nregs; a++) write_reg(a, pat);
    idle_in(); d_iss_en = 1'b1; d_iss_addr = 4;
    at_neg("iss4"); edge_step();
    idle_in(); d_clr_start = 1'b1; d_ra[0] = 4;
    at_neg("clr_start");
    check_eq("r4_busy_pre", 64'(obs_busy(0)), 64'h1);
    edge_step();
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      idle_in(); d_ra[0] = 4; d_ra[1] = 2;
      if (k == 5) begin
        d_wr_en = 1'b1; d_wr_addr = 2; d_wr_data = 64'h1111; d_iss_en = 1'b1; d_iss_addr = 2;
      end
      at_neg("clear");
      if (!obs_clr()) break;
      if (k == 0) check_eq("clr_r4_busy", 64'(obs_busy(0)), 64'h0);
      cnt++;
      edge_step();
    end
    edge_step();
    check_eq("clr_len", 64'(cnt), 64'(nregs));
    for (int a = 0; a < nregs; a++) begin
      idle_in(); d_ra[0] = 5'(a);
      at_neg("post_clr");
      check_eq("post_clr_zero", obs_data(0), 64'h0);
      edge_step();
    end

    // Reset in the middle of a clear
    for (int a = 0; a < nregs; a++) write_reg(a, pat);
    idle_in(); d_clr_start = 1'b1;
    at_neg("clr2_start"); edge_step();
    idle_in();
    for (int k = 0; k < 10; k++) begin
      at_neg("clr2"); edge_step();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("midclr_clr_busy", 64'(obs_clr()), 64'h0);
    for (int a = 0; a < nregs; a++) begin
      d_ra[0] = 5'(a);
      #1;
      check_eq("midclr_zero", obs_data(0), 64'h0);
    end
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    write_reg(6, 64'h0BADCAFE);
    idle_in(); d_ra[0] = 6;
    at_neg("rd_r6");
    check_eq("after_rst_r6", obs_data(0), 64'h0BADCAFE);
    edge_step();

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 3; p++) d_ra[p] = 5'($urandom_range(0, nregs - 1));
      d_wr_en     = ($urandom_range(0, 99) < 50);
      d_wr_addr   = 5'($urandom_range(0, nregs - 1));
      d_wr_data   = {$urandom, $urandom};
      d_iss_en    = ($urandom_range(0, 99) < 30);
      d_iss_addr  = ($urandom_range(0, 3) == 0) ? d_wr_addr : 5'($urandom_range(0, nregs - 1));
      d_flush     = ($urandom_range(0, 99) < 5);
      d_clr_start = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 3) == 0) d_ra[1] = d_wr_addr;
      at_neg("rand");
      edge_step();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    sel = 0; nregs = 32; nrd = 2; zr = 1'b1; mask = 64'h00000000_FFFFFFFF;
    run_phase();
    sel = 1; nregs = 16; nrd = 3; zr = 1'b0; mask = 64'hFFFFFFFF_FFFFFFFF;
    run_phase();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
